// File: rtl/host_write_decoder_if.sv
// rtl/host_write_decoder_if.sv - host write bus and register-bank strobe bundle
//
// Purpose : groups the asynchronous host write bus (nCS, nWR, addrIn, dataIn)
//           and the decoded register-bank outputs (regWrEn, regData, regAddr,
//           busy, addrError) of host_write_decoder.
// Modports: master - host side, drives the bus and observes the outputs
//           slave  - decoder side, samples the bus and drives the outputs
interface host_write_decoder_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16
);
    logic                  nCS;
    logic                  nWR;
    logic [ADDR_WIDTH-1:0] addrIn;
    logic [DATA_WIDTH-1:0] dataIn;
    logic [NUM_REGS-1:0]   regWrEn;
    logic [DATA_WIDTH-1:0] regData;
    logic [ADDR_WIDTH-1:0] regAddr;
    logic                  busy;
    logic                  addrError;

    modport master (
        output nCS, nWR, addrIn, dataIn,
        input  regWrEn, regData, regAddr, busy, addrError
    );

    modport slave (
        input  nCS, nWR, addrIn, dataIn,
        output regWrEn, regData, regAddr, busy, addrError
    );
endinterface

// File: rtl/host_write_decoder.sv
// rtl/host_write_decoder.sv - async host write cycles to single-cycle register write strobes
//
// Purpose : synchronizes host nCS/nWR into the clk domain, captures address and
//           data at the start of a write, and after the strobe ends issues one
//           one-hot regWrEn pulse (or an addrError pulse for out-of-range addresses).
// Ports   : clk       - FPGA clock
//           reset     - synchronous, active-high
//           bus.nCS/nWR/addrIn/dataIn          - asynchronous host write bus
//           bus.regWrEn/regData/regAddr        - register-bank write strobes and payload
//           bus.busy/addrError                 - status
// Option  : HOST_WRITE_GLITCH_FILTER_EN - adds a third sync flop per strobe line and
//           only lets the strobe change when the last two samples agree (+1 cycle
//           capture and commit latency, single-sample glitches rejected).
module host_write_decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                clk,
    input  logic                reset,
    host_write_decoder_if.slave bus
);

`ifdef HOST_WRITE_GLITCH_FILTER_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam logic [1:0]          ARM_CYCLES = 2'(SYNC_STAGES);
    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_IDLE,
        ST_STROBE,
        ST_COMMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] nwr_sync_q;
    logic                   ncs_s;
    logic                   nwr_s;
    logic                   wr_active;
    logic [1:0]             arm_cnt_q, arm_cnt_d;
    logic                   armed;
    logic [ADDR_WIDTH-1:0]  reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0]  reg_data_q, reg_data_d;
    logic                   commit;
    logic                   addr_ok;
    logic [NUM_REGS-1:0]    wr_en;

    // Bit 0 is the first (metastable) stage; the top bit is the newest safe sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            ncs_sync_q <= '1;
            nwr_sync_q <= '1;
        end else begin
            ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], bus.nCS};
            nwr_sync_q <= {nwr_sync_q[SYNC_STAGES-2:0], bus.nWR};
        end
    end

`ifdef HOST_WRITE_GLITCH_FILTER_EN
    // Each line follows the last two samples only when they agree, otherwise
    // it holds its previous filtered value.
    logic ncs_filt_q;
    logic nwr_filt_q;

    assign ncs_s = (ncs_sync_q[2] == ncs_sync_q[1]) ? ncs_sync_q[2] : ncs_filt_q;
    assign nwr_s = (nwr_sync_q[2] == nwr_sync_q[1]) ? nwr_sync_q[2] : nwr_filt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ncs_filt_q <= 1'b1;
            nwr_filt_q <= 1'b1;
        end else begin
            ncs_filt_q <= ncs_s;
            nwr_filt_q <= nwr_s;
        end
    end
`else
    assign ncs_s = ncs_sync_q[1];
    assign nwr_s = nwr_sync_q[1];
`endif

    assign wr_active = !ncs_s && !nwr_s;

    // The sync flops reset to "inactive", so right after reset they do not yet
    // reflect the bus. ARM ignores wr_active until the pipeline has refilled,
    // otherwise a strobe held low through reset would look released.
    assign armed     = (arm_cnt_q == ARM_CYCLES);
    assign arm_cnt_d = (state_q == ST_ARM && !armed) ? arm_cnt_q + 2'd1 : arm_cnt_q;

    always_comb begin
        state_d    = state_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        unique case (state_q)
            ST_ARM: begin
                if (armed && !wr_active) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (wr_active) begin
                    reg_addr_d = bus.addrIn;
                    reg_data_d = bus.dataIn;
                    state_d    = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (!wr_active) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ARM;
            arm_cnt_q  <= 2'd0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
        end
    end

    // Strobes come only from the state register and the captured address, so
    // bus activity can never leak straight through to the register bank.
    assign commit  = (state_q == ST_COMMIT);
    assign addr_ok = ({1'b0, reg_addr_q} < NUM_REGS_W);

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_en[i] = commit && addr_ok && (reg_addr_q == ADDR_WIDTH'(i));
        end
    end

    assign bus.regWrEn   = wr_en;
    assign bus.regData   = reg_data_q;
    assign bus.regAddr   = reg_addr_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.addrError = commit && !addr_ok;

endmodule
